// File: rtl/mul_m_ext_pipe_pkg.sv
// Shared definitions for the RV32M multiply pipeline.
// Contents:
//   XLEN           - architectural register width
//   MUL_F3_*       - funct3 encodings of the four RV32M multiply operations
`ifndef MUL_M_EXT_PIPE_PKG_SV
`define MUL_M_EXT_PIPE_PKG_SV

package mul_m_ext_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MUL_F3_MUL    = 3'b000;
    localparam logic [2:0] MUL_F3_MULH   = 3'b001;
    localparam logic [2:0] MUL_F3_MULHSU = 3'b010;
    localparam logic [2:0] MUL_F3_MULHU  = 3'b011;

endpackage

`endif

// File: rtl/mul_m_ext_pipe_if.sv
// Request/response handshake bundle of the multiply pipeline.
// Request side : in_valid, in_ready, in_funct3, in_op1, in_op2, in_tag
// Response side: out_valid, out_ready, out_data, out_tag, out_illegal
// Modports:
//   slave  - the pipeline (accepts requests, produces results)
//   master - the issuer/consumer (drives requests, accepts results)
interface mul_m_ext_pipe_if #(
    parameter int TAG_W = 5
);
    import mul_m_ext_pipe_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_op1;
    logic [XLEN-1:0]  in_op2;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_funct3, in_op1, in_op2, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_illegal
    );

    modport master (
        output in_valid, in_funct3, in_op1, in_op2, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_illegal
    );
endinterface

// File: rtl/mul_hi_correct.sv
// Turns the signed 32x32 core product into the RV32M result word.
// The core always treats both operands as signed; for an operand that the
// instruction wants unsigned, a set MSB made the core see (x - 2^32), so the
// upper half is short by the other operand. Adding it back fixes the high word.
// Ports:
//   mul_res  in  64  signed product from the core
//   op1/op2  in  32  operands as presented to the core
//   funct3   in  3   operation select
//   data     out 32  selected result word (0 for illegal funct3)
//   illegal  out 1   funct3[2] set
module mul_hi_correct
    import mul_m_ext_pipe_pkg::*;
(
    input  logic [2*XLEN-1:0] mul_res,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   data,
    output logic              illegal
);
    logic            w_corr_a;
    logic            w_corr_b;
    logic [XLEN-1:0] w_hi;

    // op1 unsigned only for MULHU; op2 unsigned for MULHSU and MULHU.
    assign w_corr_a = (funct3 == MUL_F3_MULHU) & op1[XLEN-1];
    assign w_corr_b = ((funct3 == MUL_F3_MULHSU) | (funct3 == MUL_F3_MULHU)) & op2[XLEN-1];

    assign w_hi = mul_res[2*XLEN-1:XLEN]
                + (w_corr_a ? op2 : '0)
                + (w_corr_b ? op1 : '0);

    always_comb begin
        data    = '0;
        illegal = 1'b0;
        if (funct3[2]) begin
            illegal = 1'b1;
        end else if (funct3 == MUL_F3_MUL) begin
            data = mul_res[XLEN-1:0];
        end else begin
            data = w_hi;
        end
    end
endmodule

// File: rtl/mul_m_ext_pipe.sv
// Two-stage valid/ready pipeline for RV32M multiplies around an external
// combinational signed 32x32 core.
//   S0: holds the request; its operand registers feed the core directly.
//   S1: holds the corrected, selected result; drives the response directly.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             kills everything in flight (dominates all advances)
//   io (slave)        request/response handshake bundle
//   mul_op1/mul_op2   operands to the signed core
//   mul_res           64-bit signed product back from the core
//   busy              any stage holds a valid operation
module mul_m_ext_pipe
    import mul_m_ext_pipe_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    mul_m_ext_pipe_if.slave   io,
    output logic [XLEN-1:0]   mul_op1,
    output logic [XLEN-1:0]   mul_op2,
    input  logic [2*XLEN-1:0] mul_res,
    output logic              busy
);
    logic             r_s0_valid;
    logic [XLEN-1:0]  r_s0_op1;
    logic [XLEN-1:0]  r_s0_op2;
    logic [2:0]       r_s0_funct3;
    logic [TAG_W-1:0] r_s0_tag;

    logic             r_s1_valid;
    logic [XLEN-1:0]  r_s1_data;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_illegal;

    logic             w_s0_en;
    logic             w_s1_en;
    logic             w_in_ready;
    logic [XLEN-1:0]  w_corr_data;
    logic             w_corr_illegal;

    // S0 can always refill when it empties into S1 this cycle, so ready
    // looks through to out_ready and the pipe runs without bubbles.
    assign w_s1_en    = r_s0_valid & (~r_s1_valid | io.out_ready);
    assign w_in_ready = ~r_s0_valid | w_s1_en;
    assign w_s0_en    = io.in_valid & w_in_ready;

    mul_hi_correct u_hi_correct (
        .mul_res (mul_res),
        .op1     (r_s0_op1),
        .op2     (r_s0_op2),
        .funct3  (r_s0_funct3),
        .data    (w_corr_data),
        .illegal (w_corr_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_valid  <= 1'b0;
            r_s0_op1    <= '0;
            r_s0_op2    <= '0;
            r_s0_funct3 <= '0;
            r_s0_tag    <= '0;
        end else if (flush) begin
            // A request handshaking in this cycle is dropped as well.
            r_s0_valid <= 1'b0;
        end else if (w_s0_en) begin
            r_s0_valid  <= 1'b1;
            r_s0_op1    <= io.in_op1;
            r_s0_op2    <= io.in_op2;
            r_s0_funct3 <= io.in_funct3;
            r_s0_tag    <= io.in_tag;
        end else if (w_s1_en) begin
            r_s0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_tag     <= '0;
            r_s1_illegal <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid   <= 1'b1;
            r_s1_data    <= w_corr_data;
            r_s1_tag     <= r_s0_tag;
            r_s1_illegal <= w_corr_illegal;
        end else if (io.out_ready) begin
            r_s1_valid <= 1'b0;
        end
    end

    assign io.in_ready    = w_in_ready;
    assign io.out_valid   = r_s1_valid;
    assign io.out_data    = r_s1_data;
    assign io.out_tag     = r_s1_tag;
    assign io.out_illegal = r_s1_illegal;
    assign mul_op1        = r_s0_op1;
    assign mul_op2        = r_s0_op2;
    assign busy           = r_s0_valid | r_s1_valid;
endmodule

// File: tb/tb_mul_m_ext_pipe.sv
// Self-checking bench for mul_m_ext_pipe. The signed core is modelled here as
// a plain signed multiply; expected results come from a 64-bit reference
// multiply of properly extended operands.
module tb_mul_m_ext_pipe;
    import mul_m_ext_pipe_pkg::*;

    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic [63:0] mul_res;

    int tests_run = 0;
    int failures  = 0;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mul_m_ext_pipe_if #(.TAG_W(TAG_W)) bus();

    assign mul_res = $signed({{32{mul_op1[31]}}, mul_op1}) * $signed({{32{mul_op2[31]}}, mul_op2});

    mul_m_ext_pipe #(.TAG_W(TAG_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .io      (bus),
        .mul_op1 (mul_op1),
        .mul_op2 (mul_op2),
        .mul_res (mul_res),
        .busy    (busy)
    );

    // Reference: full-width product of the operands extended as the
    // instruction defines them, then pick the word.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        if (f3[2]) return 32'h0;
        ea = (f3 == MUL_F3_MULHU) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (f3 == MUL_F3_MULHSU || f3 == MUL_F3_MULHU) ? {32'h0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (f3 == MUL_F3_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_funct3 = 3'b000;
        bus.in_op1    = 32'h0;
        bus.in_op2    = 32'h0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    // Issues one request into an idle pipe and waits for its result.
    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_one(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, output logic [31:0] d,
                           output logic [TAG_W-1:0] t, output logic ill, output int lat);
        bus.in_valid  = 1'b1;
        bus.in_funct3 = f3;
        bus.in_op1    = a;
        bus.in_op2    = b;
        bus.in_tag    = tag;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        d   = 32'hxxxxxxxx;
        t   = 'x;
        ill = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                d   = bus.out_data;
                t   = bus.out_tag;
                ill = bus.out_illegal;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if ({bus.out_valid, busy, bus.in_ready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_flags: got valid/busy/ready=%b required 001", {bus.out_valid, busy, bus.in_ready});
        end
        tests_run++;
        if ({bus.out_illegal, bus.out_tag, bus.out_data, mul_op1, mul_op2} !== '0) begin
            failures++;
            $display("FAIL reset_data: got illegal=%b tag=%h data=%h op1=%h op2=%h required all 0",
                     bus.out_illegal, bus.out_tag, bus.out_data, mul_op1, mul_op2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset checked");
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [5] = '{MUL_F3_MULHU, MUL_F3_MULHSU, MUL_F3_MULH, MUL_F3_MULH, MUL_F3_MUL};
        logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00010000};
        logic [31:0] bs  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00010000};
        logic [31:0] exs [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h40000000, 32'h00000000};
        logic [31:0] d;
        logic [TAG_W-1:0] t;
        logic ill;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_one(f3s[i], as[i], bs[i], TAG_W'(i + 8), d, t, ill, lat);
            $display("[TB] directed f3=%b a=%h b=%h -> data=%h tag=%0d lat=%0d", f3s[i], as[i], bs[i], d, t, lat);
            tests_run++;
            if (d !== exs[i] || ill !== 1'b0) begin
                failures++;
                $display("FAIL directed_%0d_data: got %h ill=%b required %h ill=0", i, d, ill, exs[i]);
            end
            tests_run++;
            if (t !== TAG_W'(i + 8) || lat != 2) begin
                failures++;
                $display("FAIL directed_%0d_tag_lat: got tag=%0d lat=%0d required tag=%0d lat=2", i, t, lat, i + 8);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] f3s [2] = '{3'b100, 3'b111};
        logic [31:0] d;
        logic [TAG_W-1:0] t, tag;
        logic ill;
        int lat;
        for (int i = 0; i < 2; i++) begin
            tag = TAG_W'($urandom_range(0, 31));
            run_one(f3s[i], $urandom | 32'h1, $urandom | 32'h1, tag, d, t, ill, lat);
            $display("[TB] illegal f3=%b -> data=%h ill=%b tag=%0d lat=%0d", f3s[i], d, ill, t, lat);
            tests_run++;
            if (d !== 32'h0 || ill !== 1'b1 || t !== tag || lat != 2) begin
                failures++;
                $display("FAIL illegal_%0d: got data=%h ill=%b tag=%0d lat=%0d required data=0 ill=1 tag=%0d lat=2",
                         i, d, ill, t, lat, tag);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3s [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        int next = 0;
        int got = 0;
        bit saw_not_ready = 0;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            f3s[i] = 3'($urandom_range(0, 3));
            as[i]  = $urandom;
            bs[i]  = $urandom;
        end
        sb.delete();
        for (int c = 0; c < 20; c++) begin
            bus.in_valid  = (next < 4);
            bus.in_funct3 = f3s[next % 4];
            bus.in_op1    = as[next % 4];
            bus.in_op2    = bs[next % 4];
            bus.in_tag    = TAG_W'(next + 1);
            bus.out_ready = !(c >= 2 && c <= 5);
            @(negedge clk);
            if (!bus.in_ready) saw_not_ready = 1;
            if (bus.in_valid && bus.in_ready) begin
                e.data = ref_result(f3s[next], as[next], bs[next]);
                e.tag = TAG_W'(next + 1);
                e.illegal = 1'b0;
                sb.push_back(e);
                next++;
            end
            if (bus.out_valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: got tag=%0d data=%h required no output", bus.out_tag, bus.out_data);
                end else if (bus.out_data !== sb[0].data || bus.out_tag !== sb[0].tag) begin
                    failures++;
                    $display("FAIL b2b_out cycle %0d: got tag=%0d data=%h required tag=%0d data=%h",
                             c, bus.out_tag, bus.out_data, sb[0].tag, sb[0].data);
                end
                if (bus.out_ready && sb.size() != 0) begin
                    $display("[TB] b2b result tag=%0d data=%h", bus.out_tag, bus.out_data);
                    void'(sb.pop_front());
                    got++;
                end
            end
            @(posedge clk); #1;
        end
        drive_idle();
        tests_run++;
        if (got != 4 || next != 4 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: got %0d results from %0d accepts, %0d pending, required 4/4/0", got, next, sb.size());
        end
        tests_run++;
        if (!saw_not_ready) begin
            failures++;
            $display("FAIL b2b_backpressure: got in_ready never low, required low while 2 ops held");
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [TAG_W-1:0] tag;
        int accepted = 0;
        int got = 0;
        exp_t e;
        sb.delete();
        f3 = 3'($urandom_range(0, 4)); a = $urandom; b = $urandom; tag = TAG_W'($urandom);
        for (int c = 0; c < 330; c++) begin
            bus.in_valid  = (c < 300) && ($urandom_range(0, 9) < 7);
            bus.in_funct3 = f3;
            bus.in_op1    = a;
            bus.in_op2    = b;
            bus.in_tag    = tag;
            bus.out_ready = (c >= 300) || ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                e.data = ref_result(f3, a, b);
                e.tag = tag;
                e.illegal = f3[2];
                sb.push_back(e);
                accepted++;
                f3 = 3'($urandom_range(0, 4)); a = $urandom; b = $urandom; tag = TAG_W'($urandom);
                if ($urandom_range(0, 7) == 0) a = 32'h80000000;
                if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            end
            if (bus.out_valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra: got tag=%0d data=%h required no output", bus.out_tag, bus.out_data);
                end else if (bus.out_data !== sb[0].data || bus.out_tag !== sb[0].tag
                             || bus.out_illegal !== sb[0].illegal) begin
                    failures++;
                    $display("FAIL rand_out cycle %0d: got tag=%0d data=%h ill=%b required tag=%0d data=%h ill=%b",
                             c, bus.out_tag, bus.out_data, bus.out_illegal, sb[0].tag, sb[0].data, sb[0].illegal);
                end
                if (bus.out_ready && sb.size() != 0) begin
                    void'(sb.pop_front());
                    got++;
                end
            end
            @(posedge clk); #1;
        end
        drive_idle();
        $display("[TB] random: %0d accepted, %0d returned", accepted, got);
        tests_run++;
        if (got != accepted || sb.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rand_drain: got %0d of %0d results, busy=%b required all returned, busy=0", got, accepted, busy);
        end
    endtask

    // Leaves two operations held (S1 stalled, S0 full); returns after a rising edge.
    task automatic fill_two(input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] a1, input logic [31:0] b1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_funct3 = MUL_F3_MUL;
        bus.in_op1    = a0;
        bus.in_op2    = b0;
        bus.in_tag    = TAG_W'(7);
        @(posedge clk); #1;
        bus.in_op1 = a1;
        bus.in_op2 = b1;
        bus.in_tag = TAG_W'(9);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_flush();
        int seen = 0;
        fill_two(32'd3, 32'd5, 32'd6, 32'd7);
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b1 || busy !== 1'b1 || bus.out_data !== 32'd15) begin
            failures++;
            $display("FAIL flush_pre: got valid=%b busy=%b data=%h required 1 1 0000000f", bus.out_valid, busy, bus.out_data);
        end
        @(posedge clk); #1;
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_funct3 = MUL_F3_MUL;
        bus.in_op1    = 32'd2;
        bus.in_op2    = 32'd2;
        @(posedge clk); #1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: got valid=%b busy=%b required 0 0", bus.out_valid, busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_stale: got %0d stale results required 0", seen);
        end
        $display("[TB] flush checked, stale results=%0d", seen);
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_async_reset();
        int seen = 0;
        fill_two(32'd3, 32'd5, 32'h12345678, 32'h9ABCDEF0);
        #2;
        tests_run++;
        if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: got valid=%b busy=%b required 1 1", bus.out_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.out_valid, busy, bus.in_ready, bus.out_illegal} !== 4'b0010
            || {bus.out_tag, bus.out_data, mul_op1, mul_op2} !== '0) begin
            failures++;
            $display("FAIL areset_now: got valid=%b busy=%b ready=%b ill=%b tag=%h data=%h op1=%h op2=%h required 0 0 1 0 and zeros",
                     bus.out_valid, busy, bus.in_ready, bus.out_illegal, bus.out_tag, bus.out_data, mul_op1, mul_op2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_valid || busy || !bus.in_ready) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            failures++;
            $display("FAIL areset_after: got %0d cycles with output/busy/not-ready required 0", seen);
        end
        $display("[TB] async reset checked");
        @(posedge clk); #1;
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_random();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
